conv_window_mac: RTL and testbench

Multiply-accumulate engine that directly feeds the convolution output FIFO. It consumes a stream of (image pixel, kernel weight) pairs, one KERNEL_SIZE×KERNEL_SIZE window at a time, and accumulates each window into one output pixel. It presents that pixel on `data_out` with a one-cycle `oen` strobe, stalls while the FIFO reports `fifo_full`, and pulses `done` after the last window of a job.

---
 rtl/conv_window_mac.sv | 120 ++++++++++++
 tb/tb_conv_window_mac.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_mac.sv
// Window multiply-accumulate engine: sums K*K pixel*weight pairs per output pixel,
// saturates to IW+KW bits and hands each result to the output FIFO with a one-cycle strobe.
module conv_window_mac #(
  parameter int IMAGE_PIXEL_WIDTH  = 8,
  parameter int KERNEL_PIXEL_WIDTH = 8,
  parameter int KERNEL_SIZE        = 5,
  parameter int WINDOW_COUNT_WIDTH = 16
) (
  input  logic                                          clock,
  input  logic                                          rst_n,
  input  logic                                          start,
  input  logic [WINDOW_COUNT_WIDTH-1:0]                 num_windows,
  input  logic                                          pixel_valid,
  output logic                                          pixel_ready,
  input  logic [IMAGE_PIXEL_WIDTH-1:0]                  pixel,
  input  logic [KERNEL_PIXEL_WIDTH-1:0]                 weight,
  input  logic                                          fifo_full,
  output logic [IMAGE_PIXEL_WIDTH+KERNEL_PIXEL_WIDTH-1:0] data_out,
  output logic                                          oen,
  output logic                                          done,
  output logic                                          busy
);

  localparam int TAPS  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int OW    = IMAGE_PIXEL_WIDTH + KERNEL_PIXEL_WIDTH;
  localparam int AW    = OW + $clog2(TAPS);
  localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    EMIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t                        state;
  logic [AW-1:0]                 acc;
  logic [TAP_W-1:0]              tap;
  logic [WINDOW_COUNT_WIDTH-1:0] win;
  logic [WINDOW_COUNT_WIDTH-1:0] num_lat;
  logic [OW-1:0]                 product;
  logic [AW-1:0]                 acc_next;
  logic [WINDOW_COUNT_WIDTH-1:0] win_next;

  // Any bits above the output width mean the window sum overflowed: clamp to all ones.
  function automatic logic [OW-1:0] sat(input logic [AW-1:0] x);
    if (|x[AW-1:OW]) begin
      return {OW{1'b1}};
    end else begin
      return x[OW-1:0];
    end
  endfunction

  assign product  = OW'(pixel) * OW'(weight);
  assign acc_next = acc + AW'(product);
  assign win_next = win + WINDOW_COUNT_WIDTH'(1);

  assign pixel_ready = (state == ACCUM);
  assign oen         = (state == EMIT) && !fifo_full;
  assign done        = (state == FINISH);
  assign busy        = (state != IDLE);

  // Control FSM with accumulator, tap/window counters and the held output pixel.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      tap      <= '0;
      win      <= '0;
      num_lat  <= '0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            num_lat <= num_windows;
            acc     <= '0;
            tap     <= '0;
            win     <= '0;
            state   <= (num_windows == '0) ? FINISH : ACCUM;
          end else begin
            state <= IDLE;
          end
        end
        ACCUM: begin
          if (pixel_valid) begin
            if (tap == LAST_TAP) begin
              data_out <= sat(acc_next);
              acc      <= '0;
              tap      <= '0;
              state    <= EMIT;
            end else begin
              acc <= acc_next;
              tap <= tap + TAP_W'(1);
            end
          end else begin
            state <= ACCUM;
          end
        end
        EMIT: begin
          // data_out is held here until the FIFO can take it.
          if (!fifo_full) begin
            win   <= win_next;
            state <= (win_next == num_lat) ? FINISH : ACCUM;
          end else begin
            state <= EMIT;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_mac.sv
// Directed bench for conv_window_mac with K=3, IW=KW=8: sums, saturation,
// backpressure, bubbles, empty job and mid-job reset.
module tb_conv_window_mac;

  logic        clock;
  logic        rst_n;
  logic        start;
  logic [15:0] num_windows;
  logic        pixel_valid;
  logic        pixel_ready;
  logic [7:0]  pixel;
  logic [7:0]  weight;
  logic        fifo_full;
  logic [15:0] data_out;
  logic        oen;
  logic        done;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int oen_count  = 0;
  int done_count = 0;

  conv_window_mac #(
    .IMAGE_PIXEL_WIDTH (8),
    .KERNEL_PIXEL_WIDTH(8),
    .KERNEL_SIZE       (3),
    .WINDOW_COUNT_WIDTH(16)
  ) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .start      (start),
    .num_windows(num_windows),
    .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready),
    .pixel      (pixel),
    .weight     (weight),
    .fifo_full  (fifo_full),
    .data_out   (data_out),
    .oen        (oen),
    .done       (done),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Strobe counters, sampled at the edge that consumes them.
  always @(posedge clock) begin
    if (oen)  oen_count  <= oen_count + 1;
    if (done) done_count <= done_count + 1;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_job(input logic [15:0] n);
    num_windows = n;
    start = 1'b1;
    step();
    start = 1'b0;
    num_windows = 16'hFFFF;
  endtask

  task automatic send_pair(input logic [7:0] p, input logic [7:0] w, input bit bubble);
    if (bubble) begin
      pixel_valid = 1'b0;
      step();
    end
    pixel = p;
    weight = w;
    pixel_valid = 1'b1;
    step();
    pixel_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_checks++;
    if ({oen, done, busy, pixel_ready} !== 4'b0000) begin
      $display("FAIL reset_outputs: got oen/done/busy/ready=%b expected 0000", {oen, done, busy, pixel_ready});
      n_fail++;
    end
    n_checks++;
    if (data_out !== 16'd0) begin
      $display("FAIL reset_data: got %0d expected 0", data_out);
      n_fail++;
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_window();
    int oc;
    oc = oen_count;
    start_job(16'd1);
    n_checks++;
    if ({busy, pixel_ready} !== 2'b11) begin
      $display("FAIL single_start: got busy/ready=%b expected 11", {busy, pixel_ready});
      n_fail++;
    end
    for (int i = 0; i < 9; i++) begin
      if (i == 8) begin
        n_checks++;
        if (oen !== 1'b0) begin
          $display("FAIL single_early_oen: got %b expected 0", oen);
          n_fail++;
        end
      end
      send_pair(8'd1, 8'(i + 1), 1'b0);
    end
    n_checks++;
    if (oen !== 1'b1 || data_out !== 16'd45) begin
      $display("FAIL single_emit: got oen=%b data=%0d expected oen=1 data=45", oen, data_out);
      n_fail++;
    end
    step();
    n_checks++;
    if (oen !== 1'b0 || done !== 1'b1) begin
      $display("FAIL single_done: got oen=%b done=%b expected oen=0 done=1", oen, done);
      n_fail++;
    end
    step();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || data_out !== 16'd45) begin
      $display("FAIL single_idle: got done=%b busy=%b data=%0d expected 0 0 45", done, busy, data_out);
      n_fail++;
    end
    n_checks++;
    if (oen_count - oc !== 1) begin
      $display("FAIL single_oen_count: got %0d expected 1", oen_count - oc);
      n_fail++;
    end
  endtask

  task automatic test_saturation();
    int oc;
    oc = oen_count;
    start_job(16'd1);
    for (int i = 0; i < 9; i++) send_pair(8'd255, 8'd255, 1'b0);
    n_checks++;
    if (oen !== 1'b1 || data_out !== 16'd65535) begin
      $display("FAIL sat_emit: got oen=%b data=%0d expected oen=1 data=65535", oen, data_out);
      n_fail++;
    end
    step();
    step();
    n_checks++;
    if (oen_count - oc !== 1) begin
      $display("FAIL sat_oen_count: got %0d expected 1", oen_count - oc);
      n_fail++;
    end
  endtask

  task automatic test_backpressure();
    start_job(16'd1);
    for (int i = 0; i < 8; i++) send_pair(8'd1, 8'd2, 1'b0);
    fifo_full = 1'b1;
    send_pair(8'd1, 8'd2, 1'b0);
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (oen !== 1'b0 || data_out !== 16'd18 || pixel_ready !== 1'b0) begin
        $display("FAIL bp_stall_%0d: got oen=%b data=%0d ready=%b expected 0 18 0", c, oen, data_out, pixel_ready);
        n_fail++;
      end
      if (c < 2) step();
    end
    step();
    fifo_full = 1'b0;
    #1;
    n_checks++;
    if (oen !== 1'b1 || data_out !== 16'd18) begin
      $display("FAIL bp_release: got oen=%b data=%0d expected oen=1 data=18", oen, data_out);
      n_fail++;
    end
    step();
    n_checks++;
    if (done !== 1'b1) begin
      $display("FAIL bp_done: got %b expected 1", done);
      n_fail++;
    end
    step();
  endtask

  task automatic test_bubbles();
    int oc;
    int dc;
    oc = oen_count;
    dc = done_count;
    start_job(16'd2);
    for (int i = 0; i < 9; i++) send_pair(8'(i + 1), 8'd1, 1'b1);
    n_checks++;
    if (oen !== 1'b1 || data_out !== 16'd45 || pixel_ready !== 1'b0) begin
      $display("FAIL bub_win0: got oen=%b data=%0d ready=%b expected 1 45 0", oen, data_out, pixel_ready);
      n_fail++;
    end
    for (int i = 0; i < 9; i++) send_pair(8'd3, 8'(i + 1), 1'b1);
    n_checks++;
    if (oen !== 1'b1 || data_out !== 16'd135 || pixel_ready !== 1'b0) begin
      $display("FAIL bub_win1: got oen=%b data=%0d ready=%b expected 1 135 0", oen, data_out, pixel_ready);
      n_fail++;
    end
    step();
    n_checks++;
    if (done !== 1'b1) begin
      $display("FAIL bub_done: got %b expected 1", done);
      n_fail++;
    end
    step();
    n_checks++;
    if (oen_count - oc !== 2 || done_count - dc !== 1) begin
      $display("FAIL bub_counts: got oen=%0d done=%0d expected 2 1", oen_count - oc, done_count - dc);
      n_fail++;
    end
  endtask

  task automatic test_zero_windows();
    int oc;
    oc = oen_count;
    start_job(16'd0);
    n_checks++;
    if (done !== 1'b1 || pixel_ready !== 1'b0 || oen !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL zero_done: got done=%b ready=%b oen=%b busy=%b expected 1 0 0 1", done, pixel_ready, oen, busy);
      n_fail++;
    end
    step();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || oen_count - oc !== 0) begin
      $display("FAIL zero_idle: got done=%b busy=%b oens=%0d expected 0 0 0", done, busy, oen_count - oc);
      n_fail++;
    end
  endtask

  task automatic test_reset_midjob();
    int dc;
    int oc;
    start_job(16'd1);
    for (int i = 0; i < 4; i++) send_pair(8'd7, 8'd7, 1'b0);
    dc = done_count;
    oc = oen_count;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++;
    if (busy !== 1'b0 || pixel_ready !== 1'b0 || data_out !== 16'd0) begin
      $display("FAIL abort_state: got busy=%b ready=%b data=%0d expected 0 0 0", busy, pixel_ready, data_out);
      n_fail++;
    end
    step();
    step();
    n_checks++;
    if (done_count - dc !== 0 || oen_count - oc !== 0) begin
      $display("FAIL abort_strobes: got done=%0d oen=%0d expected 0 0", done_count - dc, oen_count - oc);
      n_fail++;
    end
    start_job(16'd1);
    for (int i = 0; i < 9; i++) send_pair(8'd2, 8'd1, 1'b0);
    n_checks++;
    if (oen !== 1'b1 || data_out !== 16'd18) begin
      $display("FAIL abort_newjob: got oen=%b data=%0d expected oen=1 data=18", oen, data_out);
      n_fail++;
    end
    step();
    step();
    n_checks++;
    if (done_count - dc !== 1) begin
      $display("FAIL abort_done_count: got %0d expected 1", done_count - dc);
      n_fail++;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    num_windows = 16'd0;
    pixel_valid = 1'b0;
    pixel       = 8'd0;
    weight      = 8'd0;
    fifo_full   = 1'b0;
    test_reset();
    test_single_window();
    test_saturation();
    test_backpressure();
    test_bubbles();
    test_zero_windows();
    test_reset_midjob();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
